// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC types, port indices and routing helper
// Purpose: packet format, mesh port numbering and the dimension-ordered route
//          decision used by every router node.
// Contents: N/M port counts, LOCAL/NORTH/EAST/SOUTH/WEST indices, packet_t,
//           route_mode_e, route_port().
package noc_pkg;

    localparam int N         = 5;
    localparam int M         = 5;
    localparam int COORD_W   = 4;
    localparam int PAYLOAD_W = 8;
    localparam int PORT_W    = 3;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    typedef enum logic {
        ROUTE_XY = 1'b0,
        ROUTE_YX = 1'b1
    } route_mode_e;

    typedef struct packed {
        logic [COORD_W-1:0]   x_dest;
        logic [COORD_W-1:0]   y_dest;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;

    // Output port for a packet at node (x_loc, y_loc). North is the smaller Y.
    function automatic logic [PORT_W-1:0] route_port(
        input packet_t            pkt,
        input logic [COORD_W-1:0] x_loc,
        input logic [COORD_W-1:0] y_loc,
        input route_mode_e        mode
    );
        logic [PORT_W-1:0] x_port;
        logic [PORT_W-1:0] y_port;
        logic [PORT_W-1:0] result;
        x_port = (pkt.x_dest > x_loc) ? PORT_W'(EAST)  :
                 (pkt.x_dest < x_loc) ? PORT_W'(WEST)  : PORT_W'(LOCAL);
        y_port = (pkt.y_dest > y_loc) ? PORT_W'(SOUTH) :
                 (pkt.y_dest < y_loc) ? PORT_W'(NORTH) : PORT_W'(LOCAL);
        if (mode == ROUTE_XY) begin
            result = (x_port != PORT_W'(LOCAL)) ? x_port : y_port;
        end else begin
            result = (y_port != PORT_W'(LOCAL)) ? y_port : x_port;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating start pointer
// Purpose: grants one of N requesters, searching from the internal pointer.
// Ports: clk, reset_n (async active-low), req[N] requests, en (allow any grant),
//        gnt[N] onehot grant (all zero when en=0 or no request).
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] idx;
    logic          found;

    // Pointer moves to one past the winner so the winner has lowest priority next.
    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = PW'((int'(ptr) + k) % N);
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    ptr_next = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/router_credit.sv
// rtl/router_credit.sv - 5-port credit-flow mesh router node
// Purpose: per-input circular buffers, XY/YX routing on buffer heads, per-output
//          round-robin arbitration gated by credits, registered outputs.
// Ports: clk, reset_n (async active-low); i_data/i_data_val upstream packets;
//        o_credit slot-freed pulses upstream; o_data/o_data_val downstream
//        packets; i_credit credit returns from downstream; o_err sticky error.
module router_credit
    import noc_pkg::*;
#(
    parameter int X_LOC      = 0,
    parameter int Y_LOC      = 0,
    parameter int DEPTH      = 4,
    parameter int CREDITS    = 4,
    parameter int ROUTE_MODE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  packet_t [N-1:0]   i_data,
    input  logic    [N-1:0]   i_data_val,
    output logic    [N-1:0]   o_credit,
    output packet_t [M-1:0]   o_data,
    output logic    [M-1:0]   o_data_val,
    input  logic    [M-1:0]   i_credit,
    output logic              o_err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          CW   = $clog2(CREDITS + 1);
    localparam route_mode_e MODE = (ROUTE_MODE != 0) ? ROUTE_YX : ROUTE_XY;
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    packet_t           mem [N][DEPTH];
    logic [AW:0]       wr_ptr [N];
    logic [AW:0]       rd_ptr [N];
    logic [N-1:0]      empty, full, push, pop, ovf;
    packet_t [N-1:0]   head;
    logic [PORT_W-1:0] dest [N];

    logic [N-1:0]      req [M];
    logic [N-1:0]      gnt [M];
    logic [CW-1:0]     credit [M];
    logic [M-1:0]      grant_any, cred_ovf;
    packet_t [M-1:0]   sel_pkt;

    // Wrap bit differs and index matches -> full.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            head[i]  = mem[i][rd_ptr[i][AW-1:0]];
            dest[i]  = route_port(head[i], COORD_W'(X_LOC), COORD_W'(Y_LOC), MODE);
        end
    end

    always_comb begin
        for (int m = 0; m < M; m++) begin
            for (int i = 0; i < N; i++) begin
                req[m][i] = !empty[i] && (dest[i] == PORT_W'(m));
            end
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_arb
        rr_arbiter #(.N(N)) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (req[m]),
            .en      (credit[m] != '0),
            .gnt     (gnt[m])
        );
    end

    // A full buffer never accepts, even when it pops in the same cycle.
    always_comb begin
        pop = '0;
        for (int m = 0; m < M; m++) begin
            pop = pop | gnt[m];
        end
        push = i_data_val & ~full;
        ovf  = i_data_val & full;
    end

    always_comb begin
        for (int m = 0; m < M; m++) begin
            sel_pkt[m]   = '0;
            grant_any[m] = |gnt[m];
            for (int i = 0; i < N; i++) begin
                if (gnt[m][i]) begin
                    sel_pkt[m] = head[i];
                end
            end
            cred_ovf[m] = i_credit[m] && !grant_any[m] && (credit[m] == CRED_MAX);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= i_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            for (int m = 0; m < M; m++) begin
                credit[m] <= CRED_MAX;
            end
            o_data     <= '0;
            o_data_val <= '0;
            o_credit   <= '0;
            o_err      <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            end
            for (int m = 0; m < M; m++) begin
                if (grant_any[m] && !i_credit[m]) begin
                    credit[m] <= credit[m] - CW'(1);
                end else if (!grant_any[m] && i_credit[m] && (credit[m] != CRED_MAX)) begin
                    credit[m] <= credit[m] + CW'(1);
                end
                if (grant_any[m]) begin
                    o_data[m] <= sel_pkt[m];
                end
            end
            o_data_val <= grant_any;
            o_credit   <= pop;
            if ((|ovf) || (|cred_ovf)) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_credit.sv
// tb/tb_router_credit.sv - self-checking bench for router_credit
module tb_router_credit;
    import noc_pkg::*;

    localparam int DEPTH  = 4;
    localparam int CRED_A = 4;
    localparam int CRED_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    packet_t [N-1:0] i_data;
    logic [N-1:0]    i_data_val;
    logic [M-1:0]    i_credit_a, i_credit_b;
    logic [N-1:0]    o_credit_a, o_credit_b;
    packet_t [M-1:0] o_data_a, o_data_b;
    logic [M-1:0]    o_data_val_a, o_data_val_b;
    logic            o_err_a, o_err_b;

    int checks = 0;
    int errors = 0;

    router_credit #(.X_LOC(1), .Y_LOC(1), .DEPTH(DEPTH), .CREDITS(CRED_A), .ROUTE_MODE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_val(i_data_val),
        .o_credit(o_credit_a), .o_data(o_data_a), .o_data_val(o_data_val_a),
        .i_credit(i_credit_a), .o_err(o_err_a));

    router_credit #(.X_LOC(1), .Y_LOC(1), .DEPTH(DEPTH), .CREDITS(CRED_B), .ROUTE_MODE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_val(i_data_val),
        .o_credit(o_credit_b), .o_data(o_data_b), .o_data_val(o_data_val_b),
        .i_credit(i_credit_b), .o_err(o_err_b));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic packet_t mk_pkt(input int x, input int y, input logic [7:0] pl);
        packet_t p;
        p.x_dest  = 4'(x);
        p.y_dest  = 4'(y);
        p.payload = pl;
        return p;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        i_data     = '0;
        i_data_val = '0;
        i_credit_a = '0;
        i_credit_b = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- reference model (dut_a: node (1,1), XY) ----------------
    packet_t         mq [N][$];
    int              mcred [M];
    int              mrr [M];
    logic            merr;
    packet_t [M-1:0] e_data;
    logic [M-1:0]    e_val;
    logic [N-1:0]    e_cred;

    function automatic int route_ref(input packet_t p, input bit yx);
        int dx = int'(p.x_dest);
        int dy = int'(p.y_dest);
        int xs = (dx > 1) ? EAST : (dx < 1) ? WEST : LOCAL;
        int ys = (dy > 1) ? SOUTH : (dy < 1) ? NORTH : LOCAL;
        if (!yx) return (xs != LOCAL) ? xs : ys;
        return (ys != LOCAL) ? ys : xs;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        for (int m = 0; m < M; m++) begin
            mcred[m] = CRED_A;
            mrr[m]   = 0;
        end
        merr   = 1'b0;
        e_data = '0;
        e_val  = '0;
        e_cred = '0;
    endtask

    task automatic model_step();
        bit taken [N];
        bit was_full;
        bit found;
        int cand;
        for (int i = 0; i < N; i++) taken[i] = 1'b0;
        e_val  = '0;
        e_cred = '0;
        for (int m = 0; m < M; m++) begin
            found = 1'b0;
            if (mcred[m] > 0) begin
                for (int k = 0; k < N; k++) begin
                    cand = (mrr[m] + k) % N;
                    if (!found && mq[cand].size() > 0 && route_ref(mq[cand][0], 1'b0) == m) begin
                        found       = 1'b1;
                        taken[cand] = 1'b1;
                        e_val[m]    = 1'b1;
                        e_data[m]   = mq[cand][0];
                        mrr[m]      = (cand + 1) % N;
                    end
                end
            end
            if (e_val[m] && !i_credit_a[m]) mcred[m]--;
            else if (!e_val[m] && i_credit_a[m]) begin
                if (mcred[m] == CRED_A) merr = 1'b1;
                else mcred[m]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            was_full = (mq[i].size() == DEPTH);
            if (taken[i]) begin
                void'(mq[i].pop_front());
                e_cred[i] = 1'b1;
            end
            if (i_data_val[i]) begin
                if (was_full) merr = 1'b1;
                else mq[i].push_back(i_data[i]);
            end
        end
    endtask

    // ---------------- routing vector table ----------------
    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] in_port;
        logic [2:0] exp_xy;
        logic [2:0] exp_yx;
    } route_vec_t;

    route_vec_t vecs [8];

    initial begin
        logic [7:0] pl;
        vecs[0] = '{4'd3, 4'd1, 3'(WEST),  3'(EAST),  3'(EAST)};
        vecs[1] = '{4'd2, 4'd0, 3'(LOCAL), 3'(EAST),  3'(NORTH)};
        vecs[2] = '{4'd0, 4'd2, 3'(LOCAL), 3'(WEST),  3'(SOUTH)};
        vecs[3] = '{4'd1, 4'd0, 3'(EAST),  3'(NORTH), 3'(NORTH)};
        vecs[4] = '{4'd1, 4'd1, 3'(NORTH), 3'(LOCAL), 3'(LOCAL)};
        vecs[5] = '{4'd0, 4'd1, 3'(EAST),  3'(WEST),  3'(WEST)};
        vecs[6] = '{4'd2, 4'd3, 3'(SOUTH), 3'(EAST),  3'(SOUTH)};
        vecs[7] = '{4'd0, 4'd0, 3'(LOCAL), 3'(WEST),  3'(NORTH)};

        reset_n = 1'b1; i_data = '0; i_data_val = '0; i_credit_a = '0; i_credit_b = '0;
        #2 reset_n = 1'b0;
        #2;
        chk("reset_val",    128'(o_data_val_a), 128'(0));
        chk("reset_data",   128'(o_data_a),     128'(0));
        chk("reset_credit", 128'(o_credit_a),   128'(0));
        chk("reset_err",    128'(o_err_a),      128'(0));

        // Routing table incl. latency: nothing at t+1, output and credit at t+2.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            pl = 8'(8'h30 + v);
            i_data[vecs[v].in_port]     = mk_pkt(int'(vecs[v].x), int'(vecs[v].y), pl);
            i_data_val[vecs[v].in_port] = 1'b1;
            @(negedge clk);
            i_data_val = '0;
            chk("rt_early_a", 128'(o_data_val_a), 128'(0));
            chk("rt_early_b", 128'(o_data_val_b), 128'(0));
            @(negedge clk);
            chk("rt_val_xy",  128'(o_data_val_a), 128'(5'b00001 << vecs[v].exp_xy));
            chk("rt_val_yx",  128'(o_data_val_b), 128'(5'b00001 << vecs[v].exp_yx));
            chk("rt_credit",  128'(o_credit_a),   128'(5'b00001 << vecs[v].in_port));
            chk("rt_payload", 128'(o_data_a[vecs[v].exp_xy].payload), 128'(pl));
        end

        // Round-robin on EAST: local, north, south, then pointer at 4 favours west.
        do_reset();
        i_data[LOCAL] = mk_pkt(3, 1, 8'hA1);
        i_data[NORTH] = mk_pkt(3, 1, 8'hA2);
        i_data[SOUTH] = mk_pkt(3, 1, 8'hA3);
        i_data_val    = 5'b01011;
        @(negedge clk);
        i_data_val = '0;
        @(negedge clk);
        chk("rr1_pl", 128'(o_data_a[EAST].payload), 128'(8'hA1));
        chk("rr1_cr", 128'(o_credit_a), 128'(5'b00001));
        @(negedge clk);
        chk("rr2_pl", 128'(o_data_a[EAST].payload), 128'(8'hA2));
        chk("rr2_cr", 128'(o_credit_a), 128'(5'b00010));
        @(negedge clk);
        chk("rr3_pl", 128'(o_data_a[EAST].payload), 128'(8'hA3));
        chk("rr3_cr", 128'(o_credit_a), 128'(5'b01000));
        i_data[LOCAL] = mk_pkt(3, 1, 8'hB0);
        i_data[WEST]  = mk_pkt(3, 1, 8'hB4);
        i_data_val    = 5'b10001;
        i_credit_a[EAST] = 1'b1;
        @(negedge clk);
        i_data_val = '0; i_credit_a = '0;
        @(negedge clk);
        chk("rr4_pl", 128'(o_data_a[EAST].payload), 128'(8'hB4));
        chk("rr4_cr", 128'(o_credit_a), 128'(5'b10000));
        @(negedge clk);
        chk("rr5_pl", 128'(o_data_a[EAST].payload), 128'(8'hB0));
        chk("rr5_err", 128'(o_err_a), 128'(0));

        // Credit exhaustion on dut_b (CREDITS=2).
        do_reset();
        i_data[LOCAL] = mk_pkt(3, 1, 8'hC1);
        i_data[NORTH] = mk_pkt(3, 1, 8'hC2);
        i_data[SOUTH] = mk_pkt(3, 1, 8'hC3);
        i_data_val    = 5'b01011;
        @(negedge clk);
        i_data_val = '0;
        @(negedge clk);
        chk("cr1_pl", 128'(o_data_b[EAST].payload), 128'(8'hC1));
        @(negedge clk);
        chk("cr2_pl", 128'(o_data_b[EAST].payload), 128'(8'hC2));
        @(negedge clk);
        chk("cr3_wait", 128'(o_data_val_b[EAST]), 128'(0));
        @(negedge clk);
        chk("cr4_wait", 128'(o_data_val_b[EAST]), 128'(0));
        i_credit_b[EAST] = 1'b1;
        @(negedge clk);
        i_credit_b = '0;
        chk("cr5_wait", 128'(o_data_val_b[EAST]), 128'(0));
        @(negedge clk);
        chk("cr6_val", 128'(o_data_val_b[EAST]), 128'(1));
        chk("cr6_pl",  128'(o_data_b[EAST].payload), 128'(8'hC3));
        chk("cr6_cr",  128'(o_credit_b), 128'(5'b01000));
        i_data[LOCAL] = mk_pkt(3, 1, 8'hC4);
        i_data_val    = 5'b00001;
        @(negedge clk);
        i_data_val = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cr_zero_hold", 128'(o_data_val_b[EAST]), 128'(0));
        end
        chk("cr_err", 128'(o_err_b), 128'(0));

        // Buffer overflow on north of dut_b with SOUTH credits used up.
        do_reset();
        i_data[LOCAL] = mk_pkt(1, 3, 8'h50);
        i_data_val    = 5'b00001;
        @(negedge clk);
        i_data[LOCAL] = mk_pkt(1, 3, 8'h51);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("ovf_pre_err", 128'(o_err_b), 128'(0));
            i_data_val    = 5'b00010;
            i_data[NORTH] = mk_pkt(1, 3, 8'(8'hD0 + k));
            @(negedge clk);
        end
        i_data_val = '0;
        chk("ovf_err", 128'(o_err_b), 128'(1));
        for (int k = 0; k < 4; k++) begin
            i_credit_b[SOUTH] = 1'b1;
            @(negedge clk);
            i_credit_b = '0;
            @(negedge clk);
            chk("ovf_drain_pl", 128'(o_data_b[SOUTH].payload), 128'(8'(8'hD0 + k)));
        end
        i_credit_b[SOUTH] = 1'b1;
        @(negedge clk);
        i_credit_b = '0;
        @(negedge clk);
        chk("ovf_dropped", 128'(o_data_val_b[SOUTH]), 128'(0));
        chk("ovf_sticky",  128'(o_err_b), 128'(1));

        // Reset mid-stream.
        do_reset();
        i_data[LOCAL] = mk_pkt(3, 1, 8'hE0);
        i_data_val    = 5'b00001;
        @(negedge clk);
        i_data[LOCAL] = mk_pkt(3, 1, 8'hE1);
        @(negedge clk);
        chk("mid_pre_val", 128'(o_data_val_b[EAST]), 128'(1));
        i_data_val = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_val_b",  128'(o_data_val_b), 128'(0));
        chk("mid_data_b", 128'(o_data_b),     128'(0));
        chk("mid_cr_b",   128'(o_credit_b),   128'(0));
        chk("mid_val_a",  128'(o_data_val_a), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mid_no_stale", 128'({o_data_val_a, o_data_val_b, o_credit_b}), 128'(0));
        end
        i_data[LOCAL] = mk_pkt(3, 1, 8'hF0);
        i_data_val    = 5'b00001;
        @(negedge clk);
        i_data[LOCAL] = mk_pkt(3, 1, 8'hF1);
        @(negedge clk);
        i_data_val = '0;
        chk("mid_cred1", 128'({o_data_val_b[EAST], o_data_b[EAST].payload}), 128'({1'b1, 8'hF0}));
        @(negedge clk);
        chk("mid_cred2", 128'({o_data_val_b[EAST], o_data_b[EAST].payload}), 128'({1'b1, 8'hF1}));

        // Randomized traffic on dut_a against the queue model.
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                i_data_val[p] = ($urandom_range(0, 99) < 40);
                i_data[p]     = mk_pkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                       8'($urandom_range(0, 255)));
                i_credit_a[p] = ($urandom_range(0, 99) < 35);
            end
            model_step();
            @(negedge clk);
            chk("rnd_val",  128'(o_data_val_a), 128'(e_val));
            chk("rnd_data", 128'(o_data_a),     128'(e_data));
            chk("rnd_cred", 128'(o_credit_a),   128'(e_cred));
            chk("rnd_err",  128'(o_err_a),      128'(merr));
        end
        i_data_val = '0;
        i_credit_a = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
